// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-level interrupt controller.
//   Synchronises the external/software/timer interrupt pins, exposes them as
//   MIP pending bits, qualifies them with MIE and mstatus.MIE, picks one
//   source by fixed priority (MEI > MSI > MTI) and issues a single
//   outstanding trap request to commit with a req/ack handshake. No further
//   request is raised until MRET retires (no nesting).
//
// Ports:
//   clk, rst_n            core clock, async active-low reset
//   ext_irq/soft_irq/time_irq   raw level interrupt pins (asynchronous)
//   mstatus_mie           global interrupt enable
//   mie_meie/msie/mtie    per-source enables
//   irq_ack               commit has taken the trap this cycle
//   mret_done             MRET committed this cycle
//   irq_req               trap request to commit
//   irq_mcause            mcause value for the request
//   mip_bits              synchronised pending {MEIP, MTIP, MSIP}
//   irq_busy              handler active (acked, MRET not yet seen)
module irq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CAUSE_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ext_irq,
    input  logic               soft_irq,
    input  logic               time_irq,
    input  logic               mstatus_mie,
    input  logic               mie_meie,
    input  logic               mie_msie,
    input  logic               mie_mtie,
    input  logic               irq_ack,
    input  logic               mret_done,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] irq_mcause,
    output logic [2:0]         mip_bits,
    output logic               irq_busy
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
    typedef enum logic [1:0] {SRC_MEI, SRC_MSI, SRC_MTI} src_e;

    state_e                       state_q, state_d;
    src_e                         src_q, src_d;
    logic [CAUSE_W-1:0]           cause_q, cause_d;
    logic [SYNC_STAGES-1:0][2:0]  sync_q;

    logic meip, mtip, msip;
    logic en_mei, en_msi, en_mti, any_en, src_still;
    src_e win_src;

    // Synchroniser chain; each stage holds {ext, time, soft} in MIP order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {ext_irq, time_irq, soft_irq};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign mip_bits = sync_q[SYNC_STAGES-1];
    assign meip     = mip_bits[2];
    assign mtip     = mip_bits[1];
    assign msip     = mip_bits[0];

    assign en_mei = meip & mie_meie;
    assign en_msi = msip & mie_msie;
    assign en_mti = mtip & mie_mtie;
    assign any_en = en_mei | en_msi | en_mti;

    always_comb begin
        win_src = SRC_MTI;
        if (en_mei)      win_src = SRC_MEI;
        else if (en_msi) win_src = SRC_MSI;
    end

    // Withdraw only looks at the source that was latched; a newly arriving
    // higher-priority source does not disturb an outstanding request.
    always_comb begin
        src_still = 1'b0;
        case (src_q)
            SRC_MEI: src_still = en_mei;
            SRC_MSI: src_still = en_msi;
            SRC_MTI: src_still = en_mti;
            default: src_still = 1'b0;
        endcase
    end

    function automatic logic [CAUSE_W-1:0] cause_of(input src_e s);
        logic [CAUSE_W-1:0] c;
        c = '0;
        c[CAUSE_W-1] = 1'b1;
        case (s)
            SRC_MEI: c[3:0] = 4'd11;
            SRC_MSI: c[3:0] = 4'd3;
            default: c[3:0] = 4'd7;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (mstatus_mie && any_en) begin
                    state_d = REQ;
                    src_d   = win_src;
                    cause_d = cause_of(win_src);
                end
            end
            REQ: begin
                // Ack takes precedence over withdraw.
                if (irq_ack)                        state_d = SERVICE;
                else if (!mstatus_mie || !src_still) state_d = IDLE;
            end
            SERVICE: begin
                if (mret_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= SRC_MEI;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cause_q <= cause_d;
        end
    end

    assign irq_req    = (state_q == REQ);
    assign irq_busy   = (state_q == SERVICE);
    assign irq_mcause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_irq = 0, soft_irq = 0, time_irq = 0;
    logic        mstatus_mie = 0, mie_meie = 0, mie_msie = 0, mie_mtie = 0;
    logic        irq_ack = 0, mret_done = 0;
    logic        irq_req, irq_busy;
    logic [31:0] irq_mcause;
    logic [2:0]  mip_bits;

    int checks = 0;
    int failures = 0;

    irq_ctrl #(.SYNC_STAGES(S), .CAUSE_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_irq(ext_irq), .soft_irq(soft_irq), .time_irq(time_irq),
        .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_msie(mie_msie),
        .mie_mtie(mie_mtie), .irq_ack(irq_ack), .mret_done(mret_done),
        .irq_req(irq_req), .irq_mcause(irq_mcause), .mip_bits(mip_bits),
        .irq_busy(irq_busy)
    );

    always #5 clk = ~clk;

    // Reference model: pin history as a delay queue, handshake as two flags.
    logic        m_req, m_busy;
    logic [31:0] m_cause;
    logic [2:0]  m_mip;
    logic [2:0]  hist[$];

    function void model_reset();
        m_req = 0; m_busy = 0; m_cause = 0; m_mip = 0;
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(3'b000);
    endfunction

    function logic latched_still_pending();
        case (m_cause[3:0])
            4'd11:   return m_mip[2] & mie_meie;
            4'd3:    return m_mip[0] & mie_msie;
            4'd7:    return m_mip[1] & mie_mtie;
            default: return 1'b0;
        endcase
    endfunction

    function void model_edge();
        logic mei, msi, mti;
        mei = m_mip[2] & mie_meie;
        msi = m_mip[0] & mie_msie;
        mti = m_mip[1] & mie_mtie;
        if (m_busy) begin
            if (mret_done) m_busy = 0;
        end else if (m_req) begin
            if (irq_ack) begin
                m_req = 0; m_busy = 1;
            end else if (!mstatus_mie || !latched_still_pending()) begin
                m_req = 0;
            end
        end else if (mstatus_mie && (mei || msi || mti)) begin
            m_req = 1;
            m_cause = mei ? 32'h8000000B : (msi ? 32'h80000003 : 32'h80000007);
        end
        hist.push_back({ext_irq, time_irq, soft_irq});
        void'(hist.pop_front());
        m_mip = hist[0];
    endfunction

    // Inputs change on negedges; the model advances on each posedge and
    // outputs are observed on the following negedge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic ack_pulse();
        irq_ack = 1; tick(); irq_ack = 0;
    endtask

    task automatic mret_pulse();
        mret_done = 1; tick(); mret_done = 0;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", irq_req); end
        checks++; if (irq_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", irq_busy); end
        checks++; if (irq_mcause !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", irq_mcause); end
        checks++; if (mip_bits !== 3'b000) begin failures++; $display("FAIL reset_mip got=%b exp=000", mip_bits); end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_ext_basic();
        int hold;
        ext_irq = 1; mie_meie = 1; mstatus_mie = 1;
        tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL ext_edge1 got=%0b exp=0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL ext_edge2 got=%0b exp=0", irq_req); end
        checks++; if (mip_bits !== 3'b100) begin failures++; $display("FAIL ext_mip got=%b exp=100", mip_bits); end
        tick();
        checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL ext_edge3 got=%0b exp=1", irq_req); end
        checks++; if (irq_mcause !== 32'h8000000B) begin failures++; $display("FAIL ext_cause got=%h exp=8000000b", irq_mcause); end
        hold = 2 + $urandom_range(0, 4);
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++; if (irq_req !== 1'b1 || irq_mcause !== 32'h8000000B) begin
                failures++; $display("FAIL ext_hold req=%0b cause=%h exp 1/8000000b", irq_req, irq_mcause); end
        end
        ack_pulse();
        checks++; if (irq_req !== 1'b0 || irq_busy !== 1'b1) begin
            failures++; $display("FAIL ext_ack req=%0b busy=%0b exp 0/1", irq_req, irq_busy); end
        ext_irq = 0;
        for (int i = 0; i < S; i++) tick();
        mret_pulse();
        checks++; if (irq_busy !== 1'b0 || irq_req !== 1'b0) begin
            failures++; $display("FAIL ext_mret busy=%0b req=%0b exp 0/0", irq_busy, irq_req); end
    endtask

    task automatic test_priority();
        int n;
        ext_irq = 1; soft_irq = 1; time_irq = 1;
        mie_meie = 1; mie_msie = 1; mie_mtie = 1; mstatus_mie = 1;
        n = 0;
        while (irq_req !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (irq_mcause !== 32'h8000000B || irq_req !== 1'b1) begin
            failures++; $display("FAIL prio_mei cause=%h req=%0b exp 8000000b/1", irq_mcause, irq_req); end
        ext_irq = 0;
        ack_pulse();
        for (int i = 0; i < S; i++) tick();
        mret_pulse();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL prio_gap1 got=%0b exp=0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_mcause !== 32'h80000003) begin
            failures++; $display("FAIL prio_msi req=%0b cause=%h exp 1/80000003", irq_req, irq_mcause); end
        soft_irq = 0;
        ack_pulse();
        for (int i = 0; i < S; i++) tick();
        mret_pulse();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL prio_gap2 got=%0b exp=0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_mcause !== 32'h80000007) begin
            failures++; $display("FAIL prio_mti req=%0b cause=%h exp 1/80000007", irq_req, irq_mcause); end
    endtask

    task automatic test_withdraw();
        int n;
        time_irq = 0;
        for (int i = 0; i < S; i++) begin
            tick();
            checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL wd_sync_hold got=%0b exp=1", irq_req); end
        end
        tick();
        checks++; if (irq_req !== 1'b0 || irq_busy !== 1'b0 || irq_mcause !== 32'h80000007) begin
            failures++; $display("FAIL wd_pin req=%0b busy=%0b cause=%h exp 0/0/80000007", irq_req, irq_busy, irq_mcause); end
        time_irq = 1;
        n = 0;
        while (irq_req !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (irq_req !== 1'b1 || irq_mcause !== 32'h80000007) begin
            failures++; $display("FAIL wd_rearm req=%0b cause=%h exp 1/80000007", irq_req, irq_mcause); end
        mstatus_mie = 0;
        tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL wd_mstatus got=%0b exp=0", irq_req); end
        mstatus_mie = 1;
        tick();
        checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL wd_rereq got=%0b exp=1", irq_req); end
        // ack and withdraw condition in the same cycle: ack wins
        mstatus_mie = 0; irq_ack = 1;
        tick();
        irq_ack = 0; mstatus_mie = 1;
        checks++; if (irq_req !== 1'b0 || irq_busy !== 1'b1) begin
            failures++; $display("FAIL wd_ack_wins req=%0b busy=%0b exp 0/1", irq_req, irq_busy); end
    endtask

    task automatic test_service_ignore();
        mie_meie = 1; mie_msie = 1; mie_mtie = 1; mstatus_mie = 1;
        for (int i = 0; i < 12; i++) begin
            ext_irq = 1'($urandom); soft_irq = 1'($urandom); time_irq = 1'($urandom);
            irq_ack = 1'(i);
            tick();
            checks++; if (irq_req !== 1'b0 || irq_busy !== 1'b1) begin
                failures++; $display("FAIL svc_ignore req=%0b busy=%0b exp 0/1", irq_req, irq_busy); end
        end
        irq_ack = 0; ext_irq = 0; soft_irq = 0; time_irq = 0;
        for (int i = 0; i < S + 1; i++) tick();
        mret_pulse();
        checks++; if (irq_busy !== 1'b0 || irq_req !== 1'b0) begin
            failures++; $display("FAIL svc_mret busy=%0b req=%0b exp 0/0", irq_busy, irq_req); end
        mret_pulse();
        checks++; if (irq_busy !== 1'b0 || irq_req !== 1'b0) begin
            failures++; $display("FAIL idle_mret busy=%0b req=%0b exp 0/0", irq_busy, irq_req); end
    endtask

    task automatic test_enable_gate();
        mie_meie = 0; mie_msie = 0; mie_mtie = 0; mstatus_mie = 1;
        soft_irq = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL gate_msie got=%0b exp=0", irq_req); end
        end
        checks++; if (mip_bits !== 3'b001) begin failures++; $display("FAIL gate_mip got=%b exp=001", mip_bits); end
        mie_msie = 1;
        tick();
        checks++; if (irq_req !== 1'b1 || irq_mcause !== 32'h80000003) begin
            failures++; $display("FAIL gate_msie_on req=%0b cause=%h exp 1/80000003", irq_req, irq_mcause); end
        ack_pulse();
        mstatus_mie = 0;
        mret_pulse();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL gate_mstatus got=%0b exp=0", irq_req); end
        end
        mstatus_mie = 1;
        tick();
        checks++; if (irq_req !== 1'b1 || irq_mcause !== 32'h80000003) begin
            failures++; $display("FAIL gate_mstatus_on req=%0b cause=%h exp 1/80000003", irq_req, irq_mcause); end
        soft_irq = 0;
        ack_pulse();
        for (int i = 0; i < S; i++) tick();
        mret_pulse();
    endtask

    task automatic test_async_reset();
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            ext_irq = 1; time_irq = 1; mie_meie = 1; mie_mtie = 1; mstatus_mie = 1;
            n = 0;
            while (irq_req !== 1'b1 && n < 10) begin tick(); n++; end
            checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL arst_setup%0d got=%0b exp=1", pass, irq_req); end
            if (pass == 1) ack_pulse();
            #2 rst_n = 0;
            #1;
            model_reset();
            checks++; if (irq_req !== 1'b0 || irq_busy !== 1'b0 || irq_mcause !== 32'h0 || mip_bits !== 3'b000) begin
                failures++; $display("FAIL arst_clear%0d req=%0b busy=%0b cause=%h mip=%b exp all 0", pass, irq_req, irq_busy, irq_mcause, mip_bits); end
            @(posedge clk); @(negedge clk);
            rst_n = 1;
            for (int i = 0; i < S; i++) begin
                tick();
                checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL arst_early%0d got=%0b exp=0", pass, irq_req); end
            end
            tick();
            checks++; if (irq_req !== 1'b1 || irq_mcause !== 32'h8000000B) begin
                failures++; $display("FAIL arst_rereq%0d req=%0b cause=%h exp 1/8000000b", pass, irq_req, irq_mcause); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ext_irq  = ~ext_irq;
            if ($urandom_range(0, 7) == 0) soft_irq = ~soft_irq;
            if ($urandom_range(0, 7) == 0) time_irq = ~time_irq;
            if ($urandom_range(0, 15) == 0) mstatus_mie = ~mstatus_mie;
            if ($urandom_range(0, 15) == 0) mie_meie = ~mie_meie;
            if ($urandom_range(0, 15) == 0) mie_msie = ~mie_msie;
            if ($urandom_range(0, 15) == 0) mie_mtie = ~mie_mtie;
            irq_ack   = ($urandom_range(0, 2) == 0);
            mret_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 0;
                #1;
                model_reset();
                checks++; if (irq_req !== 1'b0 || irq_busy !== 1'b0 || mip_bits !== 3'b000) begin
                    failures++; $display("FAIL rnd_arst req=%0b busy=%0b mip=%b exp 0", irq_req, irq_busy, mip_bits); end
                #1 rst_n = 1;
            end
            tick();
            checks++; if (irq_req !== m_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%0b exp=%0b", i, irq_req, m_req); end
            checks++; if (irq_busy !== m_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", i, irq_busy, m_busy); end
            checks++; if (irq_mcause !== m_cause) begin failures++; $display("FAIL rnd_cause cyc=%0d got=%h exp=%h", i, irq_mcause, m_cause); end
            checks++; if (mip_bits !== m_mip) begin failures++; $display("FAIL rnd_mip cyc=%0d got=%b exp=%b", i, mip_bits, m_mip); end
        end
        irq_ack = 0; mret_done = 0;
    endtask

    initial begin
        test_reset();
        test_ext_basic();
        test_priority();
        test_withdraw();
        test_service_ignore();
        test_enable_gate();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
